// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolver: load-use stall FSM, predict-not-taken redirect.
// Optional perf counters enabled by BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_id,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc_id,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs1_rg,
  input  logic [4:0]      rs2_rg,
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] d2,
  input  logic [4:0]      rd_rg2,
  input  logic            memread_rg2,
  input  logic [4:0]      rd_rg3,
  input  logic            memread_rg3,
  output logic            stall_id,
  output logic            redirect_vld,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_id,
  output logic            misalign_exc,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_tk_cnt,
  output logic [CNT_W-1:0] perf_st_cnt
);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {IDLE, WAIT2, WAIT1} state_t;
  state_t state;

  logic is_br, is_jal, is_jalr, ctrl;
  logic use1, use2, haz_ex, haz_mem;
  logic resolve, taken, cond;
  logic [XLEN-1:0] jsum, target;

  always_comb begin
    is_br   = (opcode == OP_BR);
    is_jal  = (opcode == OP_JAL);
    is_jalr = (opcode == OP_JALR);
    ctrl    = valid_id && (is_br || is_jal || is_jalr) && !redirect_vld;
    use1    = is_br || is_jalr;
    use2    = is_br;
    // rd != 0 already excludes x0 sources from matching
    haz_ex  = ctrl && memread_rg2 && (rd_rg2 != 5'd0) &&
              ((use1 && rs1_rg == rd_rg2) || (use2 && rs2_rg == rd_rg2));
    haz_mem = ctrl && memread_rg3 && (rd_rg3 != 5'd0) &&
              ((use1 && rs1_rg == rd_rg3) || (use2 && rs2_rg == rd_rg3));
    stall_id = (state != IDLE) || haz_ex || haz_mem;
    resolve  = (state == IDLE) && ctrl && !haz_ex && !haz_mem;
  end

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (d1 == d2);
      3'b001:  cond = (d1 != d2);
      3'b100:  cond = ($signed(d1) <  $signed(d2));
      3'b101:  cond = ($signed(d1) >= $signed(d2));
      3'b110:  cond = (d1 <  d2);
      3'b111:  cond = (d1 >= d2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    jsum   = d1 + imm;
    target = pc_id + imm;
    unique case (1'b1)
      is_br:   taken = cond;
      is_jal:  taken = 1'b1;
      is_jalr: begin
        taken  = 1'b1;
        target = {jsum[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
      misalign_exc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (haz_ex)       state <= WAIT2;
          else if (haz_mem) state <= WAIT1;
        end
        WAIT2:   state <= WAIT1;
        WAIT1:   state <= IDLE;
        default: state <= IDLE;
      endcase
      redirect_vld <= resolve && taken;
      misalign_exc <= resolve && taken && (target[1:0] != 2'b00);
      if (resolve && taken) redirect_pc <= target;
    end
  end

  assign flush_id = redirect_vld;

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_cnt <= '0;
      perf_tk_cnt <= '0;
      perf_st_cnt <= '0;
    end else begin
      if (resolve && !(&perf_br_cnt))      perf_br_cnt <= perf_br_cnt + 1'b1;
      if (redirect_vld && !(&perf_tk_cnt)) perf_tk_cnt <= perf_tk_cnt + 1'b1;
      if (stall_id && !(&perf_st_cnt))     perf_st_cnt <= perf_st_cnt + 1'b1;
    end
  end
`else
  assign perf_br_cnt = '0;
  assign perf_tk_cnt = '0;
  assign perf_st_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit.
// Expected values are hand-computed per vector.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_id;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc_id, imm, d1, d2;
  logic [4:0]  rs1_rg, rs2_rg, rd_rg2, rd_rg3;
  logic        memread_rg2, memread_rg3;
  logic        stall_id, redirect_vld, flush_id, misalign_exc;
  logic [31:0] redirect_pc;
  logic [31:0] perf_br_cnt, perf_tk_cnt, perf_st_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .valid_id(valid_id),
    .opcode(opcode), .funct3(funct3), .pc_id(pc_id), .imm(imm),
    .rs1_rg(rs1_rg), .rs2_rg(rs2_rg), .d1(d1), .d2(d2),
    .rd_rg2(rd_rg2), .memread_rg2(memread_rg2),
    .rd_rg3(rd_rg3), .memread_rg3(memread_rg3),
    .stall_id(stall_id), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .flush_id(flush_id),
    .misalign_exc(misalign_exc),
    .perf_br_cnt(perf_br_cnt), .perf_tk_cnt(perf_tk_cnt),
    .perf_st_cnt(perf_st_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] im,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] a, input logic [31:0] b);
    valid_id = 1'b1; opcode = op; funct3 = f3;
    pc_id = pc; imm = im; rs1_rg = r1; rs2_rg = r2;
    d1 = a; d2 = b;
    rd_rg2 = 5'd0; memread_rg2 = 1'b0;
    rd_rg3 = 5'd0; memread_rg3 = 1'b0;
  endtask

  task automatic idle();
    valid_id = 1'b0;
    memread_rg2 = 1'b0;
    memread_rg3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(BR, 3'b000, 32'h0, 32'h0, 5'd1, 5'd2, 32'h0, 32'h0);
    idle();
    step(); step();
    tests++;
    if ({stall_id, redirect_vld, flush_id, misalign_exc} !== 4'b0 ||
        redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset: stall=%b rv=%b fl=%b mis=%b pc=%h want all 0",
               stall_id, redirect_vld, flush_id, misalign_exc, redirect_pc);
    end
    tests++;
    if (perf_br_cnt !== 0 || perf_tk_cnt !== 0 || perf_st_cnt !== 0) begin
      fails++;
      $display("FAIL reset_perf: br=%0d tk=%0d st=%0d want 0",
               perf_br_cnt, perf_tk_cnt, perf_st_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  // instruction held for three cycles: resolve, ignored, resolve again
  task automatic test_beq_back_to_back();
    set_in(BR, 3'b000, 32'h100, 32'h20, 5'd1, 5'd2, 32'd5, 32'd5);
    #1;
    tests++;
    if (stall_id !== 1'b0) begin
      fails++; $display("FAIL beq_stall: got %b want 0", stall_id);
    end
    step();
    tests++;
    if (redirect_vld !== 1'b1 || flush_id !== 1'b1 ||
        redirect_pc !== 32'h120 || misalign_exc !== 1'b0) begin
      fails++;
      $display("FAIL beq_redir: rv=%b fl=%b pc=%h mis=%b want 1 1 120 0",
               redirect_vld, flush_id, redirect_pc, misalign_exc);
    end
    pc_id = 32'h700;
    step();
    tests++;
    if (redirect_vld !== 1'b0 || redirect_pc !== 32'h120) begin
      fails++;
      $display("FAIL wrong_path_ignored: rv=%b pc=%h want 0 120",
               redirect_vld, redirect_pc);
    end
    step();
    tests++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h720) begin
      fails++;
      $display("FAIL back_to_back: rv=%b pc=%h want 1 720",
               redirect_vld, redirect_pc);
    end
    idle();
    step();
  endtask

  task automatic test_conditions();
    set_in(BR, 3'b100, 32'h200, 32'h40, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd1);
    step();
    tests++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h240) begin
      fails++;
      $display("FAIL blt: rv=%b pc=%h want 1 240", redirect_vld, redirect_pc);
    end
    idle();
    step();
    set_in(BR, 3'b110, 32'h300, 32'h40, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd1);
    step();
    tests++;
    if (redirect_vld !== 1'b0 || redirect_pc !== 32'h240) begin
      fails++;
      $display("FAIL bltu: rv=%b pc=%h want 0 240", redirect_vld, redirect_pc);
    end
    set_in(BR, 3'b010, 32'h300, 32'h40, 5'd1, 5'd2, 32'd3, 32'd3);
    step();
    tests++;
    if (redirect_vld !== 1'b0) begin
      fails++; $display("FAIL f3_010: rv=%b want 0", redirect_vld);
    end
    set_in(BR, 3'b101, 32'h400, 32'h4, 5'd1, 5'd2, 32'd1, 32'hFFFFFFFF);
    step();
    tests++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h404) begin
      fails++;
      $display("FAIL bge: rv=%b pc=%h want 1 404", redirect_vld, redirect_pc);
    end
    idle();
    step();
    set_in(BR, 3'b111, 32'h400, 32'h8, 5'd1, 5'd2, 32'd1, 32'hFFFFFFFF);
    step();
    tests++;
    if (redirect_vld !== 1'b0) begin
      fails++; $display("FAIL bgeu: rv=%b want 0", redirect_vld);
    end
    idle();
    step();
  endtask

  task automatic test_hazard_ex();
    set_in(BR, 3'b001, 32'h300, 32'h10, 5'd7, 5'd3, 32'd1, 32'd2);
    rd_rg2 = 5'd7; memread_rg2 = 1'b1;
    #1;
    tests++;
    if (stall_id !== 1'b1) begin
      fails++; $display("FAIL ex_detect: stall=%b want 1", stall_id);
    end
    step();
    tests++;
    if (stall_id !== 1'b1 || redirect_vld !== 1'b0) begin
      fails++;
      $display("FAIL ex_wait2: stall=%b rv=%b want 1 0", stall_id, redirect_vld);
    end
    step();
    memread_rg2 = 1'b0;
    #1;
    tests++;
    if (stall_id !== 1'b1 || redirect_vld !== 1'b0) begin
      fails++;
      $display("FAIL ex_wait1: stall=%b rv=%b want 1 0", stall_id, redirect_vld);
    end
    step();
    tests++;
    if (stall_id !== 1'b0 || redirect_vld !== 1'b0) begin
      fails++;
      $display("FAIL ex_resolve: stall=%b rv=%b want 0 0", stall_id, redirect_vld);
    end
    step();
    tests++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h310) begin
      fails++;
      $display("FAIL ex_redir: rv=%b pc=%h want 1 310", redirect_vld, redirect_pc);
    end
    idle();
    step();
  endtask

  task automatic test_hazard_mem();
    set_in(BR, 3'b000, 32'h500, 32'h8, 5'd4, 5'd9, 32'd4, 32'd4);
    rd_rg3 = 5'd9; memread_rg3 = 1'b1;
    #1;
    tests++;
    if (stall_id !== 1'b1) begin
      fails++; $display("FAIL mem_detect: stall=%b want 1", stall_id);
    end
    step();
    memread_rg3 = 1'b0;
    #1;
    tests++;
    if (stall_id !== 1'b1) begin
      fails++; $display("FAIL mem_wait1: stall=%b want 1", stall_id);
    end
    step();
    tests++;
    if (stall_id !== 1'b0 || redirect_vld !== 1'b0) begin
      fails++;
      $display("FAIL mem_resolve: stall=%b rv=%b want 0 0", stall_id, redirect_vld);
    end
    step();
    tests++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h508) begin
      fails++;
      $display("FAIL mem_redir: rv=%b pc=%h want 1 508", redirect_vld, redirect_pc);
    end
    idle();
    step();
  endtask

  task automatic test_x0();
    set_in(BR, 3'b000, 32'h600, 32'hC, 5'd0, 5'd0, 32'd0, 32'd0);
    rd_rg2 = 5'd0; memread_rg2 = 1'b1;
    rd_rg3 = 5'd0; memread_rg3 = 1'b1;
    #1;
    tests++;
    if (stall_id !== 1'b0) begin
      fails++; $display("FAIL x0_stall: stall=%b want 0", stall_id);
    end
    step();
    tests++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h60C) begin
      fails++;
      $display("FAIL x0_redir: rv=%b pc=%h want 1 60c", redirect_vld, redirect_pc);
    end
    idle();
    step();
  endtask

  task automatic test_jumps();
    set_in(JALR, 3'b000, 32'h40, 32'h0, 5'd6, 5'd0, 32'h203, 32'h0);
    step();
    tests++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h202 ||
        misalign_exc !== 1'b1) begin
      fails++;
      $display("FAIL jalr: rv=%b pc=%h mis=%b want 1 202 1",
               redirect_vld, redirect_pc, misalign_exc);
    end
    idle();
    step();
    tests++;
    if (misalign_exc !== 1'b0) begin
      fails++; $display("FAIL misalign_pulse: mis=%b want 0", misalign_exc);
    end
    // JAL reads no sources, so a matching load must not stall it
    set_in(JAL, 3'b000, 32'hFFFFFFF0, 32'h20, 5'd5, 5'd5, 32'h0, 32'h0);
    rd_rg2 = 5'd5; memread_rg2 = 1'b1;
    #1;
    tests++;
    if (stall_id !== 1'b0) begin
      fails++; $display("FAIL jal_stall: stall=%b want 0", stall_id);
    end
    step();
    tests++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h10 ||
        misalign_exc !== 1'b0) begin
      fails++;
      $display("FAIL jal_wrap: rv=%b pc=%h mis=%b want 1 10 0",
               redirect_vld, redirect_pc, misalign_exc);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_wait();
    set_in(BR, 3'b001, 32'h800, 32'h10, 5'd7, 5'd3, 32'd1, 32'd2);
    rd_rg2 = 5'd7; memread_rg2 = 1'b1;
    step();
    tests++;
    if (stall_id !== 1'b1) begin
      fails++; $display("FAIL rw_wait2: stall=%b want 1", stall_id);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #1;
    tests++;
    if (stall_id !== 1'b0 || redirect_vld !== 1'b0) begin
      fails++;
      $display("FAIL rw_after: stall=%b rv=%b want 0 0", stall_id, redirect_vld);
    end
    step();
    tests++;
    if (redirect_vld !== 1'b0 || stall_id !== 1'b0) begin
      fails++;
      $display("FAIL rw_noredir: rv=%b stall=%b want 0 0", redirect_vld, stall_id);
    end
    tests++;
    if (perf_br_cnt !== 0 || perf_tk_cnt !== 0 || perf_st_cnt !== 0) begin
      fails++;
      $display("FAIL rw_perf: br=%0d tk=%0d st=%0d want 0",
               perf_br_cnt, perf_tk_cnt, perf_st_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_beq_back_to_back();
    test_conditions();
    test_hazard_ex();
    test_hazard_mem();
    test_x0();
    test_jumps();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
